mips_cpu_bus_ctrl: RTL and testbench

Parametrised memory-access controller between the MIPS CPU core's internal requesters (instruction fetch, load/store unit, and future debug or DMA ports) and a single Avalon memory-mapped master port. It arbitrates N request channels round-robin and holds each bus cycle across `waitrequest`. It generates `byteenable` and lane-replicated write data for byte, half and word accesses, and returns lane-extracted, sign- or zero-extended load data. Misaligned accesses are flagged without issuing a bus cycle.

---
 rtl/mips_cpu_pkg.sv | 47 ++++
 rtl/mips_cpu_rr_arbiter.sv | 53 +++++
 rtl/mips_cpu_bus_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_cpu_bus_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
//
// Shared definitions for the MIPS CPU memory-access path:
//   size_t       - access size as carried by the load/store requesters
//   bus_state_t  - states of the bus controller FSM
//   AVM_*        - Avalon-MM master port widths
// Helper functions:
//   decode_size   - maps the raw 2-bit size field (11 is treated as word)
//   is_misaligned - natural-alignment check for half and word accesses
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

    localparam int AVM_ADDR_W = 32;
    localparam int AVM_DATA_W = 32;
    localparam int AVM_BE_W   = AVM_DATA_W / 8;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } bus_state_t;

    // The reserved encoding 11 behaves exactly like a word access.
    function automatic size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] lane);
        case (size)
            SIZE_HALF: return lane[0];
            SIZE_WORD: return (lane != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mips_cpu_rr_arbiter
//
// Purely combinational round-robin arbiter. The winner is the lowest
// requesting index strictly after last_grant, wrapping around, so the
// channel that was just served has the lowest priority.
//
// Parameters:
//   NUM_CH      - number of request channels (>= 1)
// Ports:
//   req         in  [NUM_CH-1:0]  request vector
//   last_grant  in  [IDX_W-1:0]   index of the previously granted channel
//   grant       out [NUM_CH-1:0]  one-hot grant (zero when nobody requests)
//   grant_idx   out [IDX_W-1:0]   binary index of the granted channel
//   grant_valid out               some channel was granted
// ---------------------------------------------------------------------------
module mips_cpu_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the channels starting just after last_grant; the walk visits
    // last_grant itself last, which gives it the lowest priority.
    always_comb begin
        cand      = last_grant;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand == IDX_W'(NUM_CH - 1)) begin
                cand = '0;
            end else begin
                cand = cand + 1'b1;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_valid = found;
    assign grant       = found ? (NUM_CH'(1) << grant_idx) : '0;

endmodule

// File: rtl/mips_cpu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mips_cpu_bus_ctrl
//
// Memory-access controller between the CPU's internal requesters (channel 0
// is instruction fetch) and one Avalon-MM master port. Requests are
// arbitrated round-robin; each accepted request becomes one bus cycle that
// is held across waitrequest. Byte/half/word stores get lane-replicated
// write data and byte enables; loads return lane-extracted, sign- or
// zero-extended data. Misaligned accesses are answered with an error
// response and never reach the bus.
//
// Optional feature macro:
//   MIPS_BUS_TIMEOUT_EN - abort a bus cycle with an error response after
//                         TIMEOUT_CYCLES wait states.
//
// Parameters:
//   NUM_CH          - number of requester channels (>= 1)
//   TIMEOUT_CYCLES  - wait-state limit (used with MIPS_BUS_TIMEOUT_EN)
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/ready  [NUM_CH]  per-channel handshake (ready is one-hot)
//   req_write        [NUM_CH]  1 = store
//   req_size         [2*NUM_CH] 00 byte, 01 half, 10/11 word
//   req_signed       [NUM_CH]  sign-extend load data
//   req_addr         [32*NUM_CH] byte address
//   req_wdata        [32*NUM_CH] right-justified store data
//   resp_valid       [NUM_CH]  one-cycle response pulse to the owner
//   resp_err, resp_rdata       response status and load result
//   address, read, write, writedata, byteenable,
//   waitrequest, readdata      Avalon-MM master port
// ---------------------------------------------------------------------------
module mips_cpu_bus_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_write,
    input  logic [2*NUM_CH-1:0]          req_size,
    input  logic [NUM_CH-1:0]            req_signed,
    input  logic [AVM_ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [AVM_DATA_W*NUM_CH-1:0] req_wdata,
    output logic [NUM_CH-1:0]            resp_valid,
    output logic                         resp_err,
    output logic [AVM_DATA_W-1:0]        resp_rdata,
    output logic [AVM_ADDR_W-1:0]        address,
    output logic                         write,
    output logic                         read,
    input  logic                         waitrequest,
    output logic [AVM_DATA_W-1:0]        writedata,
    output logic [AVM_BE_W-1:0]          byteenable,
    input  logic [AVM_DATA_W-1:0]        readdata
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mips_cpu_bus_ctrl: NUM_CH and TIMEOUT_CYCLES must be at least 1");
    end

    // Lane steering helpers for the 32-bit little-endian data path.
    function automatic logic [AVM_BE_W-1:0] lane_enables(input size_t size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 4'b0001 << lane;
            SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [AVM_DATA_W-1:0] replicate_store(input size_t size, input logic [AVM_DATA_W-1:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    function automatic logic [AVM_DATA_W-1:0] extract_load(input size_t size, input logic [1:0] lane,
                                                           input logic sign, input logic [AVM_DATA_W-1:0] data);
        logic [AVM_DATA_W-1:0] shifted;
        shifted = data >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: return sign ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
            SIZE_HALF: return sign ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
            default:   return shifted;
        endcase
    endfunction

    bus_state_t       state;
    logic [IDX_W-1:0] last_grant;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    // Latched request of the channel that owns the current transaction.
    logic [NUM_CH-1:0] owner;
    logic              lat_write;
    size_t             lat_size;
    logic              lat_signed;
    logic [1:0]        lat_lane;

    logic                  sel_write;
    size_t                 sel_size;
    logic                  sel_signed;
    logic [AVM_ADDR_W-1:0] sel_addr;
    logic [AVM_DATA_W-1:0] sel_wdata;

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    mips_cpu_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arbiter (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Acceptance is only possible in IDLE; holding it low during reset keeps
    // requesters from seeing a handshake the FSM will not act on.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    // One-hot mux of the granted channel's request fields.
    always_comb begin
        sel_write  = 1'b0;
        sel_size   = SIZE_BYTE;
        sel_signed = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_write  = req_write[i];
                sel_size   = decode_size(req_size[2*i +: 2]);
                sel_signed = req_signed[i];
                sel_addr   = req_addr[AVM_ADDR_W*i +: AVM_ADDR_W];
                sel_wdata  = req_wdata[AVM_DATA_W*i +: AVM_DATA_W];
            end
        end
    end

    // Controller FSM. All Avalon and response outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_CH - 1);
            owner      <= '0;
            lat_write  <= 1'b0;
            lat_size   <= SIZE_BYTE;
            lat_signed <= 1'b0;
            lat_lane   <= 2'b00;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
`ifdef MIPS_BUS_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_idx;
                        owner      <= grant;
                        lat_write  <= sel_write;
                        lat_size   <= sel_size;
                        lat_signed <= sel_signed;
                        lat_lane   <= sel_addr[1:0];
                        if (is_misaligned(sel_size, sel_addr[1:0])) begin
                            resp_valid <= grant;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            address    <= {sel_addr[AVM_ADDR_W-1:2], 2'b00};
                            byteenable <= lane_enables(sel_size, sel_addr[1:0]);
                            writedata  <= replicate_store(sel_size, sel_wdata);
                            read       <= !sel_write;
                            write      <= sel_write;
                            state      <= BUS;
`ifdef MIPS_BUS_TIMEOUT_EN
                            wait_cnt   <= '0;
`endif
                        end
                    end
                end

                BUS: begin
                    if (!waitrequest) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        resp_valid <= owner;
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_write ? '0 : extract_load(lat_size, lat_lane, lat_signed, readdata);
                        state      <= RESP;
                    end
`ifdef MIPS_BUS_TIMEOUT_EN
                    // Comparing against TIMEOUT_CYCLES-1 aborts on the wait
                    // state that brings the count up to TIMEOUT_CYCLES.
                    else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        resp_valid <= owner;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    resp_valid <= '0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_bus_ctrl
//
// Self-checking bench for mips_cpu_bus_ctrl (NUM_CH=2, TIMEOUT_CYCLES=4).
// Expected responses are pushed to a scoreboard queue when a request is
// accepted and popped when the DUT pulses resp_valid. The timeout scenario
// follows MIPS_BUS_TIMEOUT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_cpu_bus_ctrl;

    localparam int NUM_CH = 2;
    localparam int TO     = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_CH-1:0]      req_valid;
    logic [NUM_CH-1:0]      req_ready;
    logic [NUM_CH-1:0]      req_write;
    logic [2*NUM_CH-1:0]    req_size;
    logic [NUM_CH-1:0]      req_signed;
    logic [32*NUM_CH-1:0]   req_addr;
    logic [32*NUM_CH-1:0]   req_wdata;
    logic [NUM_CH-1:0]      resp_valid;
    logic                   resp_err;
    logic [31:0]            resp_rdata;
    logic [31:0]            address;
    logic                   write;
    logic                   read;
    logic                   waitrequest;
    logic [31:0]            writedata;
    logic [3:0]             byteenable;
    logic [31:0]            readdata;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    typedef struct packed {
        logic [NUM_CH-1:0] valid;
        logic              err;
        logic [31:0]       rdata;
    } exp_t;

    exp_t exp_q[$];

    typedef struct packed {
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] res;
    } load_case_t;

    load_case_t load_cases [6] = '{
        '{2'b00, 1'b1, 32'h0000_0002, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80},
        '{2'b00, 1'b0, 32'h0000_0002, 32'h0080_0000, 4'b0100, 32'h0000_0080},
        '{2'b01, 1'b1, 32'h0000_0202, 32'h8001_0000, 4'b1100, 32'hFFFF_8001},
        '{2'b01, 1'b0, 32'h0000_0300, 32'h1234_F00D, 4'b0011, 32'h0000_F00D},
        '{2'b00, 1'b0, 32'h0000_0043, 32'hAB00_0000, 4'b1000, 32'h0000_00AB},
        '{2'b00, 1'b1, 32'h0000_0040, 32'h0000_007F, 4'b0001, 32'h0000_007F}
    };

    mips_cpu_bus_ctrl #(
        .NUM_CH         (NUM_CH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    // Cycle index: value seen at a negedge names the cycle that began at the
    // preceding posedge.
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int ch, input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_write[ch]          = wr;
        req_size[2*ch +: 2]    = sz;
        req_signed[ch]         = sg;
        req_addr[32*ch +: 32]  = addr;
        req_wdata[32*ch +: 32] = wd;
        req_valid[ch]          = 1'b1;
    endtask

    // Waits (bounded) for req_ready[ch], then withdraws the request after the
    // accepting edge.
    task automatic wait_ready(input int ch, output bit seen, output int at);
        seen = 1'b0;
        at   = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req_ready[ch]) begin
                seen = 1'b1;
                at   = cycle;
            end
        end
        @(posedge clk);
        #1 req_valid[ch] = 1'b0;
    endtask

    task automatic wait_resp(output bit seen, output int at);
        seen = 1'b0;
        at   = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                seen = 1'b1;
                at   = cycle;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_size    = '0;
        req_signed  = '0;
        req_addr    = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        readdata    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({read, write, req_ready, resp_valid, resp_err} !== '0)
            begin failures++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {read, write, req_ready, resp_valid, resp_err}); end
        checks++;
        if ({address, writedata, byteenable} !== '0)
            begin failures++; $display("[TB] FAIL reset_bus: got %h expected 0", {address, writedata, byteenable}); end
        checks++;
        if (resp_rdata !== 32'h0)
            begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", resp_rdata); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_zero_wait_lw();
        bit seen;
        int rdy;
        int at;
        exp_t e;
        waitrequest = 1'b0;
        readdata    = 32'hDEAD_BEEF;
        next_cycle();
        drive_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0);
        exp_q.push_back('{valid: 2'b10, err: 1'b0, rdata: 32'hDEAD_BEEF});
        wait_ready(1, seen, rdy);
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL lw_ready: got none expected req_ready[1]"); end
        @(negedge clk);
        checks++;
        if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'h0000_1004, 4'b1111})
            begin failures++; $display("[TB] FAIL lw_bus: got rd=%b wr=%b addr=%h be=%b expected rd=1 wr=0 addr=00001004 be=1111", read, write, address, byteenable); end
        wait_resp(seen, at);
        checks++;
        if (!seen || at != rdy + 2)
            begin failures++; $display("[TB] FAIL lw_latency: got cycle %0d expected %0d", at, rdy + 2); end
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== e)
            begin failures++; $display("[TB] FAIL lw_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata}, e); end
    endtask

    task automatic test_load_lanes();
        bit seen;
        int rdy;
        int at;
        exp_t e;
        waitrequest = 1'b0;
        foreach (load_cases[i]) begin
            readdata = load_cases[i].rd;
            next_cycle();
            drive_req(0, 1'b0, load_cases[i].size, load_cases[i].sgn, load_cases[i].addr, 32'h0);
            exp_q.push_back('{valid: 2'b01, err: 1'b0, rdata: load_cases[i].res});
            wait_ready(0, seen, rdy);
            @(negedge clk);
            checks++;
            if ({read, address, byteenable} !== {1'b1, load_cases[i].addr[31:2], 2'b00, load_cases[i].be})
                begin failures++; $display("[TB] FAIL load_bus[%0d]: got rd=%b addr=%h be=%b expected be=%b", i, read, address, byteenable, load_cases[i].be); end
            wait_resp(seen, at);
            e = exp_q.pop_front();
            checks++;
            if (!seen || {resp_valid, resp_err, resp_rdata} !== e)
                begin failures++; $display("[TB] FAIL load_resp[%0d]: got %h expected %h", i, {resp_valid, resp_err, resp_rdata}, e); end
        end
    endtask

    task automatic test_stores();
        bit seen;
        int rdy;
        int at;
        exp_t e;
        // Byte store, zero wait: data replicated to all four lanes.
        waitrequest = 1'b0;
        next_cycle();
        drive_req(0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_12A5);
        exp_q.push_back('{valid: 2'b01, err: 1'b0, rdata: 32'h0});
        wait_ready(0, seen, rdy);
        @(negedge clk);
        checks++;
        if ({read, write, address, byteenable, writedata} !== {1'b0, 1'b1, 32'h0, 4'b0010, 32'hA5A5_A5A5})
            begin failures++; $display("[TB] FAIL sb_bus: got wr=%b addr=%h be=%b wd=%h expected wr=1 addr=0 be=0010 wd=a5a5a5a5", write, address, byteenable, writedata); end
        wait_resp(seen, at);
        e = exp_q.pop_front();
        checks++;
        if (!seen || {resp_valid, resp_err, resp_rdata} !== e)
            begin failures++; $display("[TB] FAIL sb_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata}, e); end

        // Half store held across three wait states.
        waitrequest = 1'b1;
        next_cycle();
        drive_req(0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD);
        exp_q.push_back('{valid: 2'b01, err: 1'b0, rdata: 32'h0});
        wait_ready(0, seen, rdy);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({read, write, address, byteenable, writedata, resp_valid} !== {1'b0, 1'b1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 2'b00})
                begin failures++; $display("[TB] FAIL sh_hold[%0d]: got wr=%b addr=%h be=%b wd=%h expected wr=1 addr=00000100 be=1100 wd=abcdabcd", k, write, address, byteenable, writedata); end
        end
        @(posedge clk);
        #1 waitrequest = 1'b0;
        wait_resp(seen, at);
        checks++;
        if (!seen || at != rdy + 5)
            begin failures++; $display("[TB] FAIL sh_latency: got cycle %0d expected %0d", at, rdy + 5); end
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== e)
            begin failures++; $display("[TB] FAIL sh_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata}, e); end
    endtask

    task automatic test_misaligned();
        bit seen;
        int rdy;
        exp_t e;
        int          chs   [3] = '{1, 0, 1};
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addrs [3] = '{32'h0000_1001, 32'h0000_0103, 32'h0000_1002};
        waitrequest = 1'b0;
        readdata    = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_req(chs[i], 1'b0, sizes[i], 1'b1, addrs[i], 32'h0);
            exp_q.push_back('{valid: NUM_CH'(1) << chs[i], err: 1'b1, rdata: 32'h0});
            wait_ready(chs[i], seen, rdy);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (!seen || {resp_valid, resp_err, resp_rdata} !== e || {read, write} !== 2'b00)
                begin failures++; $display("[TB] FAIL misalign_resp[%0d]: got %h rd=%b wr=%b expected %h rd=0 wr=0", i, {resp_valid, resp_err, resp_rdata}, read, write, e); end
            @(negedge clk);
            checks++;
            if ({read, write, resp_valid} !== '0)
                begin failures++; $display("[TB] FAIL misalign_nobus[%0d]: got %b expected 0", i, {read, write, resp_valid}); end
        end
    endtask

    task automatic test_back_to_back();
        int   grant_ch[$];
        int   grant_at[$];
        bit   overlap = 1'b0;
        exp_t e;
        waitrequest = 1'b0;
        readdata    = 32'h1122_3344;
        do_reset();
        drive_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        drive_req(1, 1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (req_ready != '0 && resp_valid != '0) overlap = 1'b1;
            if (req_ready == 2'b01) begin
                grant_ch.push_back(0);
                grant_at.push_back(cycle);
                exp_q.push_back('{valid: 2'b01, err: 1'b0, rdata: 32'h1122_3344});
            end else if (req_ready == 2'b10) begin
                grant_ch.push_back(1);
                grant_at.push_back(cycle);
                exp_q.push_back('{valid: 2'b10, err: 1'b0, rdata: 32'h0000_0033});
            end
            if (resp_valid != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("[TB] FAIL rr_resp: got %h expected no response", {resp_valid, resp_err, resp_rdata});
                end else begin
                    e = exp_q.pop_front();
                    if ({resp_valid, resp_err, resp_rdata} !== e)
                        begin failures++; $display("[TB] FAIL rr_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata}, e); end
                end
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid != '0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({resp_valid, resp_err, resp_rdata} !== e)
                    begin failures++; $display("[TB] FAIL rr_drain: got %h expected %h", {resp_valid, resp_err, resp_rdata}, e); end
            end
        end
        checks++;
        if (grant_ch.size() < 4 || grant_ch[0] != 0 || grant_ch[1] != 1 || grant_ch[2] != 0 || grant_ch[3] != 1)
            begin failures++; $display("[TB] FAIL rr_order: got %p expected 0,1,0,1,...", grant_ch); end
        checks++;
        if (grant_at.size() < 4 || grant_at[1] - grant_at[0] != 3 || grant_at[2] - grant_at[1] != 3 || grant_at[3] - grant_at[2] != 3)
            begin failures++; $display("[TB] FAIL rr_spacing: got %p expected spacing 3", grant_at); end
        checks++;
        if (overlap)
            begin failures++; $display("[TB] FAIL rr_ready_resp_overlap: got overlap expected none"); end
        checks++;
        if (exp_q.size() != 0)
            begin failures++; $display("[TB] FAIL rr_scoreboard_empty: got %0d left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit any_resp = 1'b0;
        int rdy;
        waitrequest = 1'b1;
        next_cycle();
        drive_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        wait_ready(0, seen, rdy);
        @(negedge clk);
        checks++;
        if (!seen || read !== 1'b1)
            begin failures++; $display("[TB] FAIL rst_mid_read: got %b expected 1", read); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({read, write} !== 2'b00)
            begin failures++; $display("[TB] FAIL rst_mid_drop: got %b expected 00", {read, write}); end
        @(posedge clk);
        #1 reset = 1'b0;
        waitrequest = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid != '0) any_resp = 1'b1;
        end
        checks++;
        if (any_resp)
            begin failures++; $display("[TB] FAIL rst_mid_noresp: got a response expected none"); end
    endtask

    task automatic test_timeout();
        bit seen;
        int rdy;
        exp_t e;
        waitrequest = 1'b1;
        readdata    = 32'h5555_AAAA;
        next_cycle();
        drive_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
`ifdef MIPS_BUS_TIMEOUT_EN
        begin
            int rd_cycles = 0;
            int at = -1;
            exp_q.push_back('{valid: 2'b10, err: 1'b1, rdata: 32'h0});
            wait_ready(1, seen, rdy);
            for (int k = 0; k < 20 && at < 0; k++) begin
                @(negedge clk);
                if (resp_valid != '0) at = cycle;
                else if (read) rd_cycles++;
            end
            checks++;
            if (rd_cycles != TO || at != rdy + TO + 1)
                begin failures++; $display("[TB] FAIL timeout_len: got %0d read cycles resp at %0d expected %0d and %0d", rd_cycles, at, TO, rdy + TO + 1); end
            e = exp_q.pop_front();
            checks++;
            if ({resp_valid, resp_err, resp_rdata, read} !== {e, 1'b0})
                begin failures++; $display("[TB] FAIL timeout_resp: got %h rd=%b expected %h rd=0", {resp_valid, resp_err, resp_rdata}, read, e); end
        end
`else
        begin
            bit any_resp = 1'b0;
            wait_ready(1, seen, rdy);
            repeat (1000) begin
                @(negedge clk);
                if (resp_valid != '0) any_resp = 1'b1;
            end
            checks++;
            if (!seen || read !== 1'b1 || any_resp)
                begin failures++; $display("[TB] FAIL no_timeout: got rd=%b resp=%b expected rd=1 resp=0", read, any_resp); end
            do_reset();
        end
`endif
        waitrequest = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait_lw();
        test_load_lanes();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
